seq_controlunit: RTL
====================

# seq_controlunit

Multi-cycle, parametrised successor to the single-cycle LEGv8 control unit. Holds its own instruction register and a step state machine (FETCH/EXEC/MEM/WB/FAULT), and drives a per-step control word and an extended immediate to the datapath. It accepts an instruction through a valid/ready handshake and stalls on a memory-ready input. It detects illegal encodings and memory timeouts. It sits between instruction memory and the datapath (regfile, ALU, PC, data memory).

## Interface
- `K_W`, default 64: constant width, minimum 32; sign and zero extension fill to `K_W`.
- `TMO_W`, default 4: width of the memory-timeout counter. Timeout limit is `2**TMO_W - 1` wait cycles.
- `clock` in 1: single clock, rising edge.
- `reset` in 1: synchronous, active-high.
- `instruction` in 32: instruction word, sampled only on an accepted handshake.
- `instr_valid` in 1: `instruction` is valid.
- `instr_ready` out 1: block accepts an instruction. Asserted exactly when state is FETCH.
- `status` in 5: `{Z64, N, Z, C, V}` = bits [4:0]. `Z64` means the register read on port B is zero.
- `mem_ready` in 1: data memory has completed the access.
- `controlword` out 11: `{pc_sel[1:0], pc_en, ir_en, rf_we, alu_b_k, status_we, mem_re, mem_we, wb_mem, halt}`, MSB first.
- `constant` out `K_W`: immediate extended from the latched IR.
- `step` out 3: current state encoding.
- `fault` out 1: sticky error flag.

## Operation
- Classes are decoded from `IR[28:25]`:
  - DPI = 100x
  - DPR = x101
  - LDST = x1x0
  - BR = 101x
  - any other value = ILLEGAL
- Load is LDST with `IR[22]=1`.
- Branch kinds:
  - B: `IR[31:26]=000101`
  - B.cond: `IR[31:24]=01010100`, condition in `IR[3:0]`, standard A64 EQ..LE, AL=1110
  - CBZ/CBNZ: `IR[30:25]=011010`, `IR[24]`=NZ
  - any other BR encoding is ILLEGAL.
- Constant:
  - DPI: zero-extended `IR[21:10]`.
  - LDST: sign-extended `IR[20:12]`.
  - B: sign-extended `{IR[25:0],2'b00}`.
  - B.cond and CB: sign-extended `{IR[23:5],2'b00}`.
  - Otherwise 0.
- State behaviour:
  - **FETCH:** `instr_ready=1` and `ir_en=instr_valid`. On valid, IR latches and the next state is EXEC; otherwise the state holds.
  - **EXEC:**
    - DPI/DPR: `rf_we=1`, `status_we=IR[29]`, `alu_b_k`=(DPI), `pc_en=1`, `pc_sel=0` (+4); next state FETCH.
    - LDST: `alu_b_k=1`, no PC update; next state MEM.
    - BR: `pc_en=1`, `pc_sel=1` (+K) if taken, else `pc_sel=0`; next state FETCH. Taken: B always; B.cond per `status[3:0]`; CBZ when `Z64=1`; CBNZ when `Z64=0`.
    - ILLEGAL: next state FAULT.
  - **MEM:**
    - `mem_re`=load, `mem_we`=store.
    - While `mem_ready=0`, the state holds and the timeout counter increments.
    - On `mem_ready=1`: a load goes to WB; a store asserts `pc_en=1`, `pc_sel=0` and goes to FETCH.
    - If the counter reaches its limit with `mem_ready` still 0, next state is FAULT.
  - **WB:** `rf_we=1`, `wb_mem=1`, `pc_en=1`, `pc_sel=0`; next state FETCH.
  - **FAULT:** `fault=1`, `halt=1`, all other controlword bits 0. Exits only on `reset`.
- The timeout counter clears on every entry to MEM.
- `step` encoding: FETCH=0, EXEC=1, MEM=2, WB=3, FAULT=4.

## Timing
- Reset values: state FETCH, IR=0, counter=0, `fault=0`, `instr_ready=1`, `controlword=0` except `ir_en` follows `instr_valid`, `constant=0`.
- Reset mid-operation (any state, including MEM or FAULT) returns to FETCH on the next edge. An in-flight memory access is abandoned, and there is no PC update on that cycle.
- `controlword` is combinational from state, IR, `status`, `instr_valid` and `mem_ready`.
- `constant` is combinational from IR only. It is valid from EXEC onward and stable until the next accepted fetch.
- Cycles per instruction, excluding fetch wait:
  - DPI/DPR/BR: 2
  - store: 3 + memory wait
  - load: 4 + memory wait
- `mem_ready=1` on the first MEM cycle means zero wait. The limit is checked before the increment, so FAULT is entered after exactly `2**TMO_W-1` wait cycles; with `TMO_W=4` that is the edge ending the 15th low cycle.
- `status` is sampled only in EXEC of a BR.

## Structure
- Package `cu_pkg`: state enum, class enum, controlword bit-index constants, `pc_sel` encodings, condition-code enum.
- Sub-module `cond_eval`: combinational, inputs `cond[3:0]` and NZCV, output taken. Reusable by a future pipelined unit.

## Test plan
- ADDI `0x91000421`, `instr_valid=1` → FETCH→EXEC. In EXEC: `constant=1`, `rf_we=1`, `alu_b_k=1`, `pc_sel=0`, `pc_en=1`. Back in FETCH after 2 cycles.
- LDUR `0xF85F8020`, `mem_ready` low 3 cycles then high → `constant=0xFFFF_FFFF_FFFF_FFF8`. Path is EXEC, MEM×4, WB with `wb_mem=1` and `rf_we=1`, then FETCH.
- B.EQ imm19=-2 (`0x54FFFFC0`): with Z=1 → `pc_sel=1`, `constant=0xFFFF_FFFF_FFFF_FFF8`; with Z=0 → `pc_sel=0`.
- STUR with `mem_ready` held 0 → FAULT after 15 MEM cycles. `fault=1` and `instr_ready=0` persist for 20 idle cycles. `reset` for 1 cycle → FETCH with `fault=0`.
- Encoding with `IR[28:25]=0000` → EXEC then FAULT, no `rf_we` or `pc_en` at any point.
- Reset asserted in MEM during a store → next cycle FETCH. `mem_we`, `pc_en` and `controlword` are 0 in that cycle except `ir_en` follows `instr_valid`.

Source files
------------

// File: rtl/cu_pkg.sv
// Shared types and constants for the multi-cycle LEGv8 control unit.
package cu_pkg;

  typedef enum logic [2:0] {
    S_FETCH = 3'd0,
    S_EXEC  = 3'd1,
    S_MEM   = 3'd2,
    S_WB    = 3'd3,
    S_FAULT = 3'd4
  } state_e;

  typedef enum logic [2:0] {
    CL_DPI,
    CL_DPR,
    CL_LDST,
    CL_BR,
    CL_ILL
  } cls_e;

  typedef enum logic [3:0] {
    CC_EQ, CC_NE, CC_CS, CC_CC, CC_MI, CC_PL, CC_VS, CC_VC,
    CC_HI, CC_LS, CC_GE, CC_LT, CC_GT, CC_LE, CC_AL, CC_NV
  } cond_e;

  localparam int CW_W         = 11;
  localparam int CW_HALT      = 0;
  localparam int CW_WB_MEM    = 1;
  localparam int CW_MEM_WE    = 2;
  localparam int CW_MEM_RE    = 3;
  localparam int CW_STATUS_WE = 4;
  localparam int CW_ALU_B_K   = 5;
  localparam int CW_RF_WE     = 6;
  localparam int CW_IR_EN     = 7;
  localparam int CW_PC_EN     = 8;
  localparam int CW_PC_SEL    = 9;

  localparam logic [1:0] PC_SEL_INC = 2'd0;
  localparam logic [1:0] PC_SEL_K   = 2'd1;

  function automatic logic is_b(input logic [31:0] ir);
    return ir[31:26] == 6'b000101;
  endfunction

  function automatic logic is_bcond(input logic [31:0] ir);
    return ir[31:24] == 8'b01010100;
  endfunction

  function automatic logic is_cb(input logic [31:0] ir);
    return ir[30:25] == 6'b011010;
  endfunction

  // Branch-class encodings that are none of B, B.cond or CB are illegal.
  function automatic cls_e decode_cls(input logic [31:0] ir);
    cls_e c;
    casez (ir[28:25])
      4'b100?: c = CL_DPI;
      4'b?101: c = CL_DPR;
      4'b?1?0: c = CL_LDST;
      4'b101?: c = (is_b(ir) || is_bcond(ir) || is_cb(ir)) ? CL_BR : CL_ILL;
      default: c = CL_ILL;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/cond_eval.sv
// A64 condition-code evaluation against NZCV flags.
module cond_eval
  import cu_pkg::*;
(
  input  logic [3:0] cond,
  input  logic [3:0] nzcv,
  output logic       taken
);
  logic n, z, c, v;
  assign {n, z, c, v} = nzcv;

  always_comb begin
    taken = 1'b0;
    case (cond_e'(cond))
      CC_EQ: taken = z;
      CC_NE: taken = !z;
      CC_CS: taken = c;
      CC_CC: taken = !c;
      CC_MI: taken = n;
      CC_PL: taken = !n;
      CC_VS: taken = v;
      CC_VC: taken = !v;
      CC_HI: taken = c && !z;
      CC_LS: taken = !(c && !z);
      CC_GE: taken = (n == v);
      CC_LT: taken = (n != v);
      CC_GT: taken = !z && (n == v);
      CC_LE: taken = !(!z && (n == v));
      default: taken = 1'b1;
    endcase
  end
endmodule

// File: rtl/seq_controlunit.sv
// Multi-cycle LEGv8 control unit: instruction register, step FSM, per-step
// control word, immediate extension, illegal-encoding and memory-timeout fault.
module seq_controlunit
  import cu_pkg::*;
#(
  parameter int K_W   = 64,
  parameter int TMO_W = 4
) (
  input  logic            clock,
  input  logic            reset,
  input  logic [31:0]     instruction,
  input  logic            instr_valid,
  output logic            instr_ready,
  input  logic [4:0]      status,
  input  logic            mem_ready,
  output logic [10:0]     controlword,
  output logic [K_W-1:0]  constant,
  output logic [2:0]      step,
  output logic            fault
);
  // Last counter value before the limit: the limit check precedes the increment.
  localparam logic [TMO_W-1:0] TMO_LAST = {{(TMO_W-1){1'b1}}, 1'b0};

  state_e           state_q, state_d;
  logic [31:0]      ir_q;
  logic [TMO_W-1:0] cnt_q;
  cls_e             cls;
  logic             is_load, cond_taken, br_taken;
  logic [CW_W-1:0]  cw;

  assign cls     = decode_cls(ir_q);
  assign is_load = ir_q[22];

  cond_eval u_cond (
    .cond  (ir_q[3:0]),
    .nzcv  (status[3:0]),
    .taken (cond_taken)
  );

  always_comb begin
    br_taken = 1'b0;
    if (is_b(ir_q))          br_taken = 1'b1;
    else if (is_bcond(ir_q)) br_taken = cond_taken;
    else if (is_cb(ir_q))    br_taken = ir_q[24] ? !status[4] : status[4];
  end

  always_comb begin
    constant = '0;
    case (cls)
      CL_DPI:  constant = {{(K_W-12){1'b0}}, ir_q[21:10]};
      CL_LDST: constant = {{(K_W-9){ir_q[20]}}, ir_q[20:12]};
      CL_BR:
        if (is_b(ir_q)) constant = {{(K_W-28){ir_q[25]}}, ir_q[25:0], 2'b00};
        else            constant = {{(K_W-21){ir_q[23]}}, ir_q[23:5], 2'b00};
      default: constant = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= S_FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      if (state_q == S_FETCH && instr_valid) ir_q <= instruction;
      if (state_q == S_EXEC)                      cnt_q <= '0;
      else if (state_q == S_MEM && !mem_ready)    cnt_q <= cnt_q + 1'b1;
    end
  end

  always_comb begin
    state_d = state_q;
    cw      = '0;
    case (state_q)
      S_FETCH: begin
        cw[CW_IR_EN] = instr_valid;
        if (instr_valid) state_d = S_EXEC;
      end
      S_EXEC: begin
        case (cls)
          CL_DPI, CL_DPR: begin
            cw[CW_RF_WE]     = 1'b1;
            cw[CW_STATUS_WE] = ir_q[29];
            cw[CW_ALU_B_K]   = (cls == CL_DPI);
            cw[CW_PC_EN]     = 1'b1;
            state_d          = S_FETCH;
          end
          CL_LDST: begin
            cw[CW_ALU_B_K] = 1'b1;
            state_d        = S_MEM;
          end
          CL_BR: begin
            cw[CW_PC_EN]           = 1'b1;
            cw[CW_PC_SEL +: 2]     = br_taken ? PC_SEL_K : PC_SEL_INC;
            state_d                = S_FETCH;
          end
          default: state_d = S_FAULT;
        endcase
      end
      S_MEM: begin
        cw[CW_MEM_RE] = is_load;
        cw[CW_MEM_WE] = !is_load;
        if (mem_ready) begin
          if (is_load) state_d = S_WB;
          else begin
            cw[CW_PC_EN] = 1'b1;
            state_d      = S_FETCH;
          end
        end else if (cnt_q == TMO_LAST) begin
          state_d = S_FAULT;
        end
      end
      S_WB: begin
        cw[CW_RF_WE]  = 1'b1;
        cw[CW_WB_MEM] = 1'b1;
        cw[CW_PC_EN]  = 1'b1;
        state_d       = S_FETCH;
      end
      default: cw[CW_HALT] = 1'b1;
    endcase
    // A reset cycle abandons any in-flight access and never moves the PC.
    if (reset) begin
      cw           = '0;
      cw[CW_IR_EN] = instr_valid;
    end
  end

  assign controlword = cw;
  assign instr_ready = (state_q == S_FETCH);
  assign fault       = (state_q == S_FAULT);
  assign step        = state_q;
endmodule
